des_f_pipe: RTL and testbench

Two-stage pipelined DES round function f(R,K) with a valid/ready handshake on both sides.
- Stage 1 applies the E expansion to the 32-bit half-block and XORs it with the 48-bit round subkey.
- Stage 2 feeds the eight 6-bit chunks through the codebase's s_box_1..s_box_8 lookup modules and applies the P permutation.
- The block sits between the round-key scheduler/round controller and the Feistel XOR/swap stage of the iterative DES datapath, and accepts one operation per cycle.

---
 rtl/des_pkg.sv | 54 +++++
 rtl/des_s_box.sv | 75 +++++++
 rtl/des_sbox_layer.sv | 19 +
 rtl/des_f_pipe.sv | 86 ++++++++
 tb/tb_des_f_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared DES constants and bit-permutation helpers.
//   DES_HALF_W / DES_SUBKEY_W : half-block and round subkey widths
//   E_TABLE / P_TABLE         : expansion and P permutation, DES numbering
//                               (bit 1 = MSB of the vector)
//   des_expand()              : 32 -> 48 E expansion
//   des_permute_p()           : 32 -> 32 P permutation
//   sbox_pick()               : 4-bit lookup from a packed 4x16 S-box table
package des_pkg;

  localparam int DES_HALF_W   = 32;
  localparam int DES_SUBKEY_W = 48;

  localparam int E_TABLE [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TABLE [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // DES bit b lives at vector index (width - b); output bit 1 is the MSB.
  function automatic logic [47:0] des_expand(input logic [31:0] r);
    logic [47:0] e;
    e = '0;
    for (int i = 0; i < 48; i++) begin
      e[6'(47 - i)] = r[5'(32 - E_TABLE[i])];
    end
    return e;
  endfunction

  function automatic logic [31:0] des_permute_p(input logic [31:0] s);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      p[5'(31 - i)] = s[5'(32 - P_TABLE[i])];
    end
    return p;
  endfunction

  // Table is packed row 0 first, column 0 first, one nibble per entry.
  // Row = chunk bits 1 and 6, column = chunk bits 2..5. Entry n sits at
  // nibble offset (63 - n) from the LSB, and 63 - n == ~n for 6 bits.
  function automatic logic [3:0] sbox_pick(input logic [255:0] tbl,
                                           input logic [5:0]   idx);
    logic [5:0] n;
    n = {idx[5], idx[0], idx[4:1]};
    return tbl[{~n, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/des_s_box.sv
// s_box_1 .. s_box_8: the eight DES substitution boxes.
//   din  [5:0] : 6-bit chunk, din[5] = chunk bit 1
//   dout [3:0] : 4-bit substitution result, dout[3] = result bit 1
// Purely combinational.
module s_box_1 import des_pkg::*; (
  input  logic [5:0] din,
  output logic [3:0] dout
);
  localparam logic [255:0] TBL = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                                  64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
  assign dout = sbox_pick(TBL, din);
endmodule

module s_box_2 import des_pkg::*; (
  input  logic [5:0] din,
  output logic [3:0] dout
);
  localparam logic [255:0] TBL = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                                  64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
  assign dout = sbox_pick(TBL, din);
endmodule

module s_box_3 import des_pkg::*; (
  input  logic [5:0] din,
  output logic [3:0] dout
);
  localparam logic [255:0] TBL = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
                                  64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
  assign dout = sbox_pick(TBL, din);
endmodule

module s_box_4 import des_pkg::*; (
  input  logic [5:0] din,
  output logic [3:0] dout
);
  localparam logic [255:0] TBL = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                                  64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
  assign dout = sbox_pick(TBL, din);
endmodule

module s_box_5 import des_pkg::*; (
  input  logic [5:0] din,
  output logic [3:0] dout
);
  localparam logic [255:0] TBL = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                                  64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
  assign dout = sbox_pick(TBL, din);
endmodule

module s_box_6 import des_pkg::*; (
  input  logic [5:0] din,
  output logic [3:0] dout
);
  localparam logic [255:0] TBL = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                                  64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
  assign dout = sbox_pick(TBL, din);
endmodule

module s_box_7 import des_pkg::*; (
  input  logic [5:0] din,
  output logic [3:0] dout
);
  localparam logic [255:0] TBL = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                                  64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
  assign dout = sbox_pick(TBL, din);
endmodule

module s_box_8 import des_pkg::*; (
  input  logic [5:0] din,
  output logic [3:0] dout
);
  localparam logic [255:0] TBL = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                                  64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
  assign dout = sbox_pick(TBL, din);
endmodule

// File: rtl/des_sbox_layer.sv
// des_sbox_layer: the full DES S-layer, eight S-boxes side by side.
//   x [47:0] : expanded, key-mixed half-block; x[47:42] feeds s_box_1
//   s [31:0] : concatenated S-box outputs, s_box_1 result in s[31:28]
// Purely combinational.
module des_sbox_layer import des_pkg::*; (
  input  logic [DES_SUBKEY_W-1:0] x,
  output logic [DES_HALF_W-1:0]   s
);

  s_box_1 u_s1 (.din(x[47:42]), .dout(s[31:28]));
  s_box_2 u_s2 (.din(x[41:36]), .dout(s[27:24]));
  s_box_3 u_s3 (.din(x[35:30]), .dout(s[23:20]));
  s_box_4 u_s4 (.din(x[29:24]), .dout(s[19:16]));
  s_box_5 u_s5 (.din(x[23:18]), .dout(s[15:12]));
  s_box_6 u_s6 (.din(x[17:12]), .dout(s[11:8]));
  s_box_7 u_s7 (.din(x[11:6]),  .dout(s[7:4]));
  s_box_8 u_s8 (.din(x[5:0]),   .dout(s[3:0]));

endmodule

// File: rtl/des_f_pipe.sv
// des_f_pipe: two-stage pipelined DES round function f(R,K).
//   Stage 1: s1_x = E(r_in) ^ k_in
//   Stage 2: s2_f = P(S(s1_x))
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake for r_in, k_in, tag_in
//   r_in  [31:0]        : right half-block, r_in[31] = DES bit 1
//   k_in  [47:0]        : round subkey, k_in[47] = DES bit 1
//   tag_in [TAG_W-1:0]  : sideband tag, carried through unchanged
//   out_valid/out_ready : output handshake for f_out, tag_out
//   f_out [31:0]        : f(R,K), registered
//   tag_out [TAG_W-1:0] : tag of the result, registered
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holds its data stable while valid is high and ready is low;
// ready never depends on the valid it is paired with (in_ready is a
// function of out_ready and the registered stage valid bits only).
module des_f_pipe import des_pkg::*; #(
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DES_HALF_W-1:0]   r_in,
  input  logic [DES_SUBKEY_W-1:0] k_in,
  input  logic [TAG_W-1:0]        tag_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DES_HALF_W-1:0]   f_out,
  output logic [TAG_W-1:0]        tag_out
);

  logic                    s1_valid;
  logic [DES_SUBKEY_W-1:0] s1_x;
  logic [TAG_W-1:0]        s1_tag;
  logic                    s2_valid;
  logic [DES_HALF_W-1:0]   s2_f;
  logic [TAG_W-1:0]        s2_tag;

  logic                    s1_adv;
  logic                    s2_adv;
  logic [DES_HALF_W-1:0]   sbox_out;

  // A stage may load when it is empty or its contents move on this edge,
  // so a full pipe with out_ready high still accepts a new operation.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid = s2_valid;
  assign f_out     = s2_f;
  assign tag_out   = s2_tag;

  des_sbox_layer u_sbox_layer (
    .x (s1_x),
    .s (sbox_out)
  );

  // Data registers load whenever the stage advances, even with valid low;
  // that data is never observed because the valid bit travels with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      s1_x     <= des_expand(r_in) ^ k_in;
      s1_tag   <= tag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_f     <= '0;
      s2_tag   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      s2_f     <= des_permute_p(sbox_out);
      s2_tag   <= s1_tag;
    end
  end

endmodule

// File: tb/tb_des_f_pipe.sv
// tb_des_f_pipe: directed and randomised checks for des_f_pipe.
// Main instance (TAG_W=4) takes the directed scenarios; two extra
// instances (TAG_W=1, TAG_W=8) share one random stream checked against an
// independent reference model of f(R,K).
module tb_des_f_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- main instance signals ----------------
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] r_in, f_out;
  logic [47:0] k_in;
  logic [3:0]  tag_in, tag_out;

  // ---------------- random-stream instances ----------------
  logic        rv_valid, rv_oready;
  logic [31:0] rv_r;
  logic [47:0] rv_k;
  logic [7:0]  rv_tag;
  logic        w1_in_ready, w1_out_valid;
  logic [31:0] w1_f;
  logic [0:0]  w1_tag;
  logic        w8_in_ready, w8_out_valid;
  logic [31:0] w8_f;
  logic [7:0]  w8_tag;

  int checks   = 0;
  int failures = 0;

  logic [39:0] exp_q[$];   // TAG_W=8 instance: {tag, f}
  logic [32:0] exp1_q[$];  // TAG_W=1 instance: {tag, f}

  localparam logic [31:0] KAT_R  = 32'hF0AAF0AA;
  localparam logic [47:0] KAT_K  = 48'h1B02EFFC7072;
  localparam logic [47:0] KAT_X  = 48'h6117BA866527;
  localparam logic [31:0] KAT_F  = 32'h234AA9BB;
  localparam logic [31:0] ZERO_S = 32'hEFA72C4D;
  localparam logic [31:0] ZERO_F = 32'hD8D8DBBC;

  des_f_pipe #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .r_in(r_in), .k_in(k_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .f_out(f_out), .tag_out(tag_out)
  );

  des_f_pipe #(.TAG_W(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .in_valid(rv_valid), .in_ready(w1_in_ready),
    .r_in(rv_r), .k_in(rv_k), .tag_in(rv_tag[0:0]),
    .out_valid(w1_out_valid), .out_ready(rv_oready),
    .f_out(w1_f), .tag_out(w1_tag)
  );

  des_f_pipe #(.TAG_W(8)) dut_w8 (
    .clk(clk), .rst(rst),
    .in_valid(rv_valid), .in_ready(w8_in_ready),
    .r_in(rv_r), .k_in(rv_k), .tag_in(rv_tag),
    .out_valid(w8_out_valid), .out_ready(rv_oready),
    .f_out(w8_f), .tag_out(w8_tag)
  );

  // ---------------- reference model ----------------
  localparam logic [63:0] SBOX_ROWS [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // E is built from its structure: chunk j takes DES bits 4j .. 4j+5,
  // wrapping 0 -> 32 and 33 -> 1.
  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] f;
    logic [5:0]  c;
    logic [63:0] rowv;
    int          desbit;
    int          row;
    int          col;
    x = '0;
    s = '0;
    f = '0;
    for (int j = 0; j < 8; j++) begin
      for (int b = 0; b < 6; b++) begin
        desbit = ((4 * j + b + 31) % 32) + 1;
        x[47 - (6 * j + b)] = r[32 - desbit];
      end
    end
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      c    = x[47 - 6 * j -: 6];
      row  = int'(c[5]) * 2 + int'(c[0]);
      col  = int'(c[4:1]);
      rowv = SBOX_ROWS[4 * j + row];
      s[31 - 4 * j -: 4] = 4'((rowv >> (4 * (15 - col))) & 64'hF);
    end
    for (int i = 0; i < 32; i++) begin
      f[31 - i] = s[32 - P_TAB[i]];
    end
    return f;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic drive_op(input logic [31:0] r, input logic [47:0] k, input logic [3:0] t);
    in_valid = 1'b1;
    r_in     = r;
    k_in     = k;
    tag_in   = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; r_in = '0; k_in = '0; tag_in = '0;
    rv_valid = 1'b0; rv_oready = 1'b1; rv_r = '0; rv_k = '0; rv_tag = '0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (f_out !== 32'h0) begin failures++; $display("FAIL reset_f_out got=%h exp=00000000", f_out); end
    checks++; if (tag_out !== 4'h0) begin failures++; $display("FAIL reset_tag_out got=%h exp=0", tag_out); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (w8_out_valid !== 1'b0) begin failures++; $display("FAIL reset_w8_out_valid got=%b exp=0", w8_out_valid); end
    rst = 1'b0;
  endtask

  task automatic test_known_answer();
    out_ready = 1'b1;
    drive_op(KAT_R, KAT_K, 4'd1);
    step();
    in_valid = 1'b0;
    checks++; if (dut.s1_x !== KAT_X) begin failures++; $display("FAIL kat_stage1 got=%h exp=%h", dut.s1_x, KAT_X); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL kat_early_valid got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL kat_out_valid got=%b exp=1", out_valid); end
    checks++; if (f_out !== KAT_F) begin failures++; $display("FAIL kat_f_out got=%h exp=%h", f_out, KAT_F); end
    checks++; if (tag_out !== 4'd1) begin failures++; $display("FAIL kat_tag_out got=%h exp=1", tag_out); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL kat_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_zero_vector();
    out_ready = 1'b1;
    drive_op(32'h0, 48'h0, 4'd0);
    step();
    in_valid = 1'b0;
    checks++; if (dut.sbox_out !== ZERO_S) begin failures++; $display("FAIL zero_sbox got=%h exp=%h", dut.sbox_out, ZERO_S); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL zero_out_valid got=%b exp=1", out_valid); end
    checks++; if (f_out !== ZERO_F) begin failures++; $display("FAIL zero_f_out got=%h exp=%h", f_out, ZERO_F); end
    checks++; if (tag_out !== 4'd0) begin failures++; $display("FAIL zero_tag_out got=%h exp=0", tag_out); end
    step();
  endtask

  // Even tags carry the known-answer vector, odd tags the zero vector.
  task automatic test_back_to_back();
    logic [31:0] exp_f;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        if (c % 2 == 0) drive_op(KAT_R, KAT_K, 4'(c));
        else            drive_op(32'h0, 48'h0, 4'(c));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 8) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      if (c >= 2) begin
        exp_f = ((c - 2) % 2 == 0) ? KAT_F : ZERO_F;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_out_valid c=%0d got=%b exp=1", c, out_valid); end
        checks++; if (tag_out !== 4'(c - 2)) begin failures++; $display("FAIL b2b_tag c=%0d got=%h exp=%h", c, tag_out, 4'(c - 2)); end
        checks++; if (f_out !== exp_f) begin failures++; $display("FAIL b2b_f c=%0d got=%h exp=%h", c, f_out, exp_f); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_fill c=%0d got=%b exp=0", c, out_valid); end
      end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_f [2];
    logic [3:0]  exp_t [2];
    exp_f[0] = ZERO_F; exp_t[0] = 4'd2;
    exp_f[1] = KAT_F;  exp_t[1] = 4'd3;
    out_ready = 1'b0;
    drive_op(KAT_R, KAT_K, 4'd1);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept_a got=%b exp=1", in_ready); end
    step();
    drive_op(32'h0, 48'h0, 4'd2);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept_b got=%b exp=1", in_ready); end
    step();
    drive_op(KAT_R, KAT_K, 4'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready i=%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_stall_valid i=%0d got=%b exp=1", i, out_valid); end
      checks++; if (f_out !== KAT_F) begin failures++; $display("FAIL bp_stall_f i=%0d got=%h exp=%h", i, f_out, KAT_F); end
      checks++; if (tag_out !== 4'd1) begin failures++; $display("FAIL bp_stall_tag i=%0d got=%h exp=1", i, tag_out); end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    checks++; if (tag_out !== 4'd1) begin failures++; $display("FAIL bp_release_tag got=%h exp=1", tag_out); end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid i=%0d got=%b exp=1", i, out_valid); end
      checks++; if (tag_out !== exp_t[i]) begin failures++; $display("FAIL bp_drain_tag i=%0d got=%h exp=%h", i, tag_out, exp_t[i]); end
      checks++; if (f_out !== exp_f[i]) begin failures++; $display("FAIL bp_drain_f i=%0d got=%h exp=%h", i, f_out, exp_f[i]); end
      step();
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    step();
  endtask

  task automatic test_reset_mid_flight();
    out_ready = 1'b0;
    drive_op(KAT_R, KAT_K, 4'd6);
    step();
    drive_op(32'h0, 48'h0, 4'd7);
    step();
    in_valid = 1'b0;
    checks++; if (tag_out !== 4'd6) begin failures++; $display("FAIL rmf_loaded_tag got=%h exp=6", tag_out); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmf_out_valid got=%b exp=0", out_valid); end
    checks++; if (f_out !== 32'h0) begin failures++; $display("FAIL rmf_f_out got=%h exp=00000000", f_out); end
    checks++; if (tag_out !== 4'h0) begin failures++; $display("FAIL rmf_tag_out got=%h exp=0", tag_out); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmf_in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmf_stale i=%0d got=%b exp=0", i, out_valid); end
    end
    drive_op(KAT_R, KAT_K, 4'd9);
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmf_new_valid got=%b exp=1", out_valid); end
    checks++; if (f_out !== KAT_F) begin failures++; $display("FAIL rmf_new_f got=%h exp=%h", f_out, KAT_F); end
    checks++; if (tag_out !== 4'd9) begin failures++; $display("FAIL rmf_new_tag got=%h exp=9", tag_out); end
    step();
  endtask

  // Pipe occupancy equals the scoreboard depth, so in_ready must be
  // (depth < 2) || out_ready.
  task automatic test_tag_width();
    int          accepted;
    int          cycles;
    logic        acc8;
    logic        exp_rdy;
    logic [39:0] e8;
    logic [32:0] e1;
    logic [31:0] f_model;
    accepted = 0;
    cycles   = 0;
    acc8     = 1'b0;
    rv_valid = 1'b0;
    while (cycles < 20000 && (accepted < 1000 || exp_q.size() > 0 || exp1_q.size() > 0)) begin
      step();
      cycles++;
      if (!rv_valid || acc8) begin
        rv_valid = (accepted < 1000) && ($urandom_range(0, 3) != 0);
        rv_r     = $urandom;
        rv_k     = {16'($urandom), 32'($urandom)};
        rv_tag   = 8'($urandom);
      end
      rv_oready = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      exp_rdy = (exp_q.size() < 2) || rv_oready;
      checks++; if (w8_in_ready !== exp_rdy) begin failures++; $display("FAIL w8_in_ready cyc=%0d got=%b exp=%b", cycles, w8_in_ready, exp_rdy); end
      exp_rdy = (exp1_q.size() < 2) || rv_oready;
      checks++; if (w1_in_ready !== exp_rdy) begin failures++; $display("FAIL w1_in_ready cyc=%0d got=%b exp=%b", cycles, w1_in_ready, exp_rdy); end
      if (w8_out_valid && rv_oready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL w8_spurious cyc=%0d got=%h exp=none", cycles, {w8_tag, w8_f});
        end else begin
          e8 = exp_q.pop_front();
          if ({w8_tag, w8_f} !== e8) begin failures++; $display("FAIL w8_result cyc=%0d got=%h exp=%h", cycles, {w8_tag, w8_f}, e8); end
        end
      end
      if (w1_out_valid && rv_oready) begin
        checks++;
        if (exp1_q.size() == 0) begin
          failures++; $display("FAIL w1_spurious cyc=%0d got=%h exp=none", cycles, {w1_tag, w1_f});
        end else begin
          e1 = exp1_q.pop_front();
          if ({w1_tag, w1_f} !== e1) begin failures++; $display("FAIL w1_result cyc=%0d got=%h exp=%h", cycles, {w1_tag, w1_f}, e1); end
        end
      end
      f_model = ref_f(rv_r, rv_k);
      acc8 = rv_valid && w8_in_ready;
      if (acc8) begin
        exp_q.push_back({rv_tag, f_model});
        accepted++;
      end
      if (rv_valid && w1_in_ready) exp1_q.push_back({rv_tag[0], f_model});
    end
    checks++; if (cycles >= 20000) begin failures++; $display("FAIL random_timeout got=%0d cycles exp<20000", cycles); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL w8_leftover got=%0d exp=0", exp_q.size()); end
    checks++; if (exp1_q.size() != 0) begin failures++; $display("FAIL w1_leftover got=%0d exp=0", exp1_q.size()); end
    rv_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_known_answer();
    test_zero_vector();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_flight();
    test_tag_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
